// File: rtl/f_sqrt.sv
// Pipelined IEEE-754 binary32 square root, 3-cycle latency, one operand per clock.
// Define F_SQRT_SUBNORMAL_EN to normalize subnormal operands; otherwise they flush to a signed zero.
module f_sqrt (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in,
    output logic [31:0] out
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    // Partial remainder and partial root of the digit-by-digit integer square root.
    typedef struct packed {
        logic [27:0] rem;
        logic [24:0] root;
    } sq_t;

    function automatic sq_t sqrt_step(input sq_t cur, input logic [1:0] bits);
        logic [27:0] r;
        logic [27:0] t;
        sq_t         nx;
        r = {cur.rem[25:0], bits};
        t = {1'b0, cur.root, 2'b01};
        if (r >= t) begin
            nx.rem  = r - t;
            nx.root = {cur.root[23:0], 1'b1};
        end else begin
            nx.rem  = r;
            nx.root = {cur.root[23:0], 1'b0};
        end
        return nx;
    endfunction

    logic [23:0]       sig_norm;
    logic signed [9:0] exp_unb;
    logic signed [9:0] exp_half;
    logic              zero_like;
    logic              s1_spec_d;
    logic [31:0]       s1_val_d;
    logic [7:0]        s1_exp_d;
    logic [49:0]       s1_rad_d;

`ifdef F_SQRT_SUBNORMAL_EN
    function automatic logic [4:0] msb_pos(input logic [22:0] f);
        logic [4:0] pos;
        pos = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (f[i]) pos = 5'(i);
        end
        return pos;
    endfunction

    logic [4:0] sub_pos;
    assign sub_pos   = msb_pos(in[22:0]);
    assign zero_like = (in[30:23] == 8'h00) && (in[22:0] == 23'd0);
`else
    assign zero_like = (in[30:23] == 8'h00);
`endif

    // Stage 1: classify, normalize, and form the integer radicand (odd exponents pre-shifted).
    always_comb begin
        sig_norm = {1'b1, in[22:0]};
        exp_unb  = $signed({2'b00, in[30:23]}) - 10'sd127;
`ifdef F_SQRT_SUBNORMAL_EN
        if (in[30:23] == 8'h00) begin
            sig_norm = 24'(in[22:0]) << (5'd23 - sub_pos);
            exp_unb  = $signed({5'b00000, sub_pos}) - 10'sd149;
        end
`endif
        exp_half  = exp_unb >>> 1;
        s1_exp_d  = 8'(exp_half + 10'sd127);
        s1_rad_d  = exp_unb[0] ? {sig_norm, 26'd0} : {1'b0, sig_norm, 25'd0};
        s1_spec_d = 1'b1;
        s1_val_d  = QNAN;
        if (in[30:23] == 8'hFF) begin
            s1_val_d = (in[22:0] != 23'd0 || in[31]) ? QNAN : PINF;
        end else if (zero_like) begin
            s1_val_d = {in[31], 31'd0};
        end else if (!in[31]) begin
            s1_spec_d = 1'b0;
        end
    end

    logic        s1_spec_q, s2_spec_q, s3_spec_q;
    logic [31:0] s1_val_q,  s2_val_q,  s3_val_q;
    logic [7:0]  s1_exp_q,  s2_exp_q,  s3_exp_q;
    logic [49:0] s1_rad_q;
    logic [23:0] s2_rad_q;
    sq_t         s2_sq_q;
    logic [24:0] s3_root_q;
    logic        s3_sticky_q;
    logic [31:0] out_q;
    logic [31:0] out_d;

    sq_t row_a [0:13];
    sq_t row_b [0:12];

    assign row_a[0] = '0;
    assign row_b[0] = s2_sq_q;

    genvar gi;
    generate
        for (gi = 0; gi < 13; gi = gi + 1) begin : g_row_a
            assign row_a[gi+1] = sqrt_step(row_a[gi], s1_rad_q[49-2*gi -: 2]);
        end
        for (gi = 0; gi < 12; gi = gi + 1) begin : g_row_b
            assign row_b[gi+1] = sqrt_step(row_b[gi], s2_rad_q[23-2*gi -: 2]);
        end
    endgenerate

    logic        round_up;
    logic [24:0] mant_sum;

    // A cleared slot has no hidden bit, so it assembles to +0.
    always_comb begin
        round_up = s3_root_q[0] & (s3_sticky_q | s3_root_q[1]);
        mant_sum = {1'b0, s3_root_q[24:1]} + {24'd0, round_up};
        out_d    = 32'd0;
        if (s3_spec_q) begin
            out_d = s3_val_q;
        end else if (mant_sum[24]) begin
            out_d = {1'b0, s3_exp_q + 8'd1, 23'd0};
        end else if (mant_sum[23]) begin
            out_d = {1'b0, s3_exp_q, mant_sum[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_spec_q   <= 1'b0;
            s1_val_q    <= '0;
            s1_exp_q    <= '0;
            s1_rad_q    <= '0;
            s2_spec_q   <= 1'b0;
            s2_val_q    <= '0;
            s2_exp_q    <= '0;
            s2_rad_q    <= '0;
            s2_sq_q     <= '0;
            s3_spec_q   <= 1'b0;
            s3_val_q    <= '0;
            s3_exp_q    <= '0;
            s3_root_q   <= '0;
            s3_sticky_q <= 1'b0;
            out_q       <= '0;
        end else begin
            s1_spec_q   <= s1_spec_d;
            s1_val_q    <= s1_val_d;
            s1_exp_q    <= s1_exp_d;
            s1_rad_q    <= s1_rad_d;
            s2_spec_q   <= s1_spec_q;
            s2_val_q    <= s1_val_q;
            s2_exp_q    <= s1_exp_q;
            s2_rad_q    <= s1_rad_q[23:0];
            s2_sq_q     <= row_a[13];
            s3_spec_q   <= s2_spec_q;
            s3_val_q    <= s2_val_q;
            s3_exp_q    <= s2_exp_q;
            s3_root_q   <= row_b[12].root;
            s3_sticky_q <= (row_b[12].rem != 28'd0);
            out_q       <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_f_sqrt.sv
// Self-checking bench for f_sqrt: directed vectors, reset behaviour and a random sweep
// compared against a real-arithmetic reference rounded to binary32.
module tb_f_sqrt;

`ifdef F_SQRT_SUBNORMAL_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [31:0] dout;

    int checks = 0;
    int errors = 0;

    logic [31:0] ev_h [$];
    bit          rst_h [$];

    f_sqrt dut (
        .clk (clk),
        .rst (rst),
        .in  (din),
        .out (dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
        bit          s = a[31];
        int          e = int'(a[30:23]);
        int          f = int'(a[22:0]);
        real         x;
        logic [63:0] d;
        int          fe;
        logic [23:0] mant;
        if (e == 255) return (f != 0 || s) ? 32'h7FC0_0000 : 32'h7F80_0000;
        if (e == 0 && f == 0) return {s, 31'd0};
        if (e == 0 && !SUB_EN) return {s, 31'd0};
        if (s) return 32'h7FC0_0000;
        if (e == 0) x = real'(f) * (2.0 ** (-149.0));
        else        x = (1.0 + real'(f) / 8388608.0) * (2.0 ** real'(e - 127));
        d    = $realtobits($sqrt(x));
        fe   = int'(d[62:52]) - 1023 + 127;
        mant = {1'b0, d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) mant = mant + 24'd1;
        if (mant[23]) fe = fe + 1;
        return {1'b0, 8'(fe), mant[22:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: out=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Output after edge k: the operand from edge k-3, or zero if reset hit any edge in between.
    function automatic logic [31:0] expect_at(input int k);
        for (int j = k; j >= k - 3; j--) begin
            if (j < 0 || rst_h[j]) return 32'h0;
        end
        return ev_h[k-3];
    endfunction

    task automatic step(input logic [31:0] a, input bit r, input bit use_c,
                        input logic [31:0] c, input string tag);
        int          k;
        logic [31:0] e;
        din = a;
        rst = r;
        @(posedge clk);
        ev_h.push_back(use_c ? c : ref_sqrt(a));
        rst_h.push_back(r);
        k = ev_h.size() - 1;
        @(negedge clk);
        e = expect_at(k);
        check_eq(tag, dout, e);
        if (tag != "rnd")
            $display("[%s] edge=%0d in=%08h rst=%0d out=%08h exp=%08h", tag, k, a, r, dout, e);
    endtask

    function automatic logic [31:0] rand_pos();
        int sel = int'($urandom_range(0, 9));
        if (sel < 7) return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        if (sel < 9) return {9'd0, 23'($urandom)};
        return $urandom;
    endfunction

    logic [31:0] dir_in [0:15] = '{
        32'h4000_0000, 32'h1F80_0000, 32'h1F00_0000, 32'h9BB5_56C0,
        32'h8000_0000, 32'h7F80_0000, 32'h7FA0_0001, 32'h0040_0000,
        32'h0080_0000, 32'h0000_0000, 32'hFF80_0000, 32'h807F_FFFF,
        32'h7FFF_FFFF, 32'h7F7F_FFFF, 32'h0000_0001, 32'h3F80_0001
    };
    logic [31:0] dir_exp [0:15] = '{
        32'h3FB5_04F3, 32'h2F80_0000, 32'h2F35_04F3, 32'h7FC0_0000,
        32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000,
        (SUB_EN ? 32'h1FB5_04F3 : 32'h0000_0000),
        32'h2000_0000, 32'h0000_0000, 32'h7FC0_0000,
        (SUB_EN ? 32'h7FC0_0000 : 32'h8000_0000),
        32'h7FC0_0000, 32'h0, 32'h0, 32'h0
    };
    bit dir_c [0:15] = '{1,1,1,1, 1,1,1,1, 1,1,1,1, 1,0,0,0};

    initial begin
        rst = 1'b1;
        din = 32'h0;
        @(negedge clk);
        step(32'h4080_0000, 1'b1, 1'b1, 32'h4000_0000, "rst");
        step(32'h4080_0000, 1'b1, 1'b1, 32'h4000_0000, "rst");
        for (int i = 0; i < 5; i++) step(32'h4080_0000, 1'b0, 1'b1, 32'h4000_0000, "rst");
        for (int i = 0; i < 16; i++) step(dir_in[i], 1'b0, dir_c[i], dir_exp[i], "dir");
        for (int i = 0; i < 20000; i++) step(rand_pos(), 1'b0, 1'b0, 32'h0, "rnd");
        for (int i = 0; i < 3; i++) step(rand_pos(), 1'b0, 1'b0, 32'h0, "mid");
        step(32'h4080_0000, 1'b1, 1'b0, 32'h0, "mid");
        for (int i = 0; i < 5; i++) step(rand_pos(), 1'b0, 1'b0, 32'h0, "mid");
        for (int i = 0; i < 4; i++) step(32'h3F80_0000, 1'b0, 1'b1, 32'h3F80_0000, "end");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
